// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, request size/direction codes
// and the byte-address wrap helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  // Byte address of lane k of an access starting at addr, wrapping inside the array.
  function automatic int unsigned wrap_idx(int unsigned addr, int unsigned k,
                                           int unsigned depth);
    return (addr + k) % depth;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Wait-state counter: clear/enable controlled, done when the count reaches WaitCycles.
module dmem_wait_counter #(
  parameter int unsigned WaitCycles = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 4'(WaitCycles));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request, WAIT_CYCLES wait states and a
// one-cycle response. Optional word-alignment checking is enabled by DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e state_q, state_d;

  logic              rw_q, size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic cnt_clr, cnt_en, cnt_done;
  logic accept, enter_resp;

  logic              eff_rw, eff_size;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic [IdxW-1:0]   idx [4];
  logic              align_err;

  logic [7:0] mem [DEPTH];

  dmem_wait_counter #(
    .WaitCycles (WAIT_CYCLES)
  ) u_wait_counter (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  // The counter advances on the accepting edge too, so WAIT cycles see counts 1..WAIT_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (cnt_done) begin
          state_d = StResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StResp: begin
        cnt_clr = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // With zero wait states the request commits on its own accepting edge, before it is latched.
  always_comb begin
    if (state_q == StIdle) begin
      eff_rw    = req_rw;
      eff_size  = req_size;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end else begin
      eff_rw    = rw_q;
      eff_size  = size_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      idx[k] = IdxW'(wrap_idx(32'(eff_addr), k, DEPTH));
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (eff_size == SIZE_WORD) && (eff_addr[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= req_rw;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= enter_resp & align_err;
      if (enter_resp && (eff_rw == RW_READ)) begin
        if (align_err) begin
          rdata_q <= '0;
        end else if (eff_size == SIZE_BYTE) begin
          rdata_q <= {24'h0, mem[idx[0]]};
        end else begin
          rdata_q <= {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
        end
      end
    end
  end

  // Storage is never cleared; a reset on the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && (eff_rw == RW_WRITE) && !align_err) begin
      if (eff_size == SIZE_BYTE) begin
        mem[idx[0]] <= eff_wdata[7:0];
      end else begin
        mem[idx[0]] <= eff_wdata[31:24];
        mem[idx[1]] <= eff_wdata[23:16];
        mem[idx[2]] <= eff_wdata[15:8];
        mem[idx[3]] <= eff_wdata[7:0];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign stall     = (state_q == StWait);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: randomized requests against a byte-array model.
module tb_dmem_responder;

  localparam int unsigned W = 1;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_rw, req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  dmem_responder #(
    .ADDR_W      (8),
    .DEPTH       (256),
    .WAIT_CYCLES (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain byte array plus the last read response.
  logic [7:0]  mdl [256];
  logic [31:0] mdl_last;

  // Observations of the most recent transaction.
  int          lat, sc, br;
  logic [31:0] rd;
  logic        er, pr, pv, pe;
  time         ta;
  logic [31:0] e_rd;
  logic        e_er;

  function automatic logic exp_err(logic size, logic [7:0] a);
    return ALIGN && size && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] exp_rd(logic size, logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    if (exp_err(size, a)) return 32'h0;
    if (!size) return {24'h0, mdl[a]};
    return {mdl[a], mdl[a1], mdl[a2], mdl[a3]};
  endfunction

  // Records expected response fields, then applies the request to the model.
  task automatic mdl_apply(input logic rw, input logic size, input logic [7:0] a,
                           input logic [31:0] wd);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    e_er = exp_err(size, a);
    if (!rw) begin
      mdl_last = exp_rd(size, a);
    end else if (!e_er) begin
      if (!size) begin
        mdl[a] = wd[7:0];
      end else begin
        mdl[a]  = wd[31:24];
        mdl[a1] = wd[23:16];
        mdl[a2] = wd[15:8];
        mdl[a3] = wd[7:0];
      end
    end
    e_rd = mdl_last;
  endtask

  // Entered just after a negedge in IDLE; returns just after the negedge following RESP.
  task automatic do_txn(input logic rw, input logic size, input logic [7:0] a,
                        input logic [31:0] wd);
    req_rw    = rw;
    req_size  = size;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    ta = $time;
    #1;
    // Junk while busy must be ignored.
    req_rw    = 1'($urandom);
    req_size  = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    lat = -1;
    sc  = 0;
    br  = 0;
    rd  = '0;
    er  = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (req_ready) br++;
      if (stall) sc++;
      if (rsp_valid) begin
        lat = n;
        rd  = rsp_rdata;
        er  = rsp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    pr = req_ready;
    pv = rsp_valid;
    pe = rsp_err;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_size  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl_last = 32'h0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", rsp_err); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", req_ready); end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) begin
      logic [31:0] wd;
      wd = $urandom;
      mdl_apply(1'b1, 1'b0, 8'(a), wd);
      do_txn(1'b1, 1'b0, 8'(a), wd);
      tests++;
      if (lat != int'(W) + 1) begin
        fails++; $display("FAIL fill_latency addr %0d got %0d want %0d", a, lat, W + 1);
      end
    end
  endtask

  task automatic test_word_rw();
    logic [7:0]  ba [4];
    logic [31:0] bv [4];
    ba = '{8'h10, 8'h11, 8'h12, 8'h13};
    bv = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};
    mdl_apply(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    do_txn(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    tests++; if (lat != 2) begin fails++; $display("FAIL wr_latency got %0d want 2", lat); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL wr_err got %b want 0", er); end
    tests++; if (rd !== e_rd) begin fails++; $display("FAIL wr_rdata_hold got %h want %h", rd, e_rd); end
    for (int i = 0; i < 4; i++) begin
      mdl_apply(1'b0, 1'b0, ba[i], 32'h0);
      do_txn(1'b0, 1'b0, ba[i], 32'h0);
      tests++;
      if (rd !== bv[i]) begin
        fails++; $display("FAIL byte_rd %h got %h want %h", ba[i], rd, bv[i]);
      end
    end
    mdl_apply(1'b0, 1'b1, 8'h10, 32'h0);
    do_txn(1'b0, 1'b1, 8'h10, 32'h0);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_rd got %h want deadbeef", rd); end
    // Wrap across the top of the array.
    mdl_apply(1'b1, 1'b1, 8'hFE, 32'h11223344);
    do_txn(1'b1, 1'b1, 8'hFE, 32'h11223344);
    tests++; if (er !== e_er) begin fails++; $display("FAIL wrap_wr_err got %b want %b", er, e_er); end
    ba = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) begin
      mdl_apply(1'b0, 1'b0, ba[i], 32'h0);
      do_txn(1'b0, 1'b0, ba[i], 32'h0);
      tests++;
      if (rd !== e_rd) begin
        fails++; $display("FAIL wrap_byte_rd %h got %h want %h", ba[i], rd, e_rd);
      end
    end
  endtask

  task automatic test_align();
    logic [31:0] wd;
    wd = $urandom;
    mdl_apply(1'b1, 1'b1, 8'h21, wd);
    do_txn(1'b1, 1'b1, 8'h21, wd);
    tests++; if (er !== e_er) begin fails++; $display("FAIL unal_wr_err got %b want %b", er, e_er); end
    tests++; if (lat != int'(W) + 1) begin fails++; $display("FAIL unal_latency got %0d want %0d", lat, W + 1); end
    for (int i = 0; i < 4; i++) begin
      mdl_apply(1'b0, 1'b0, 8'(8'h21 + i), 32'h0);
      do_txn(1'b0, 1'b0, 8'(8'h21 + i), 32'h0);
      tests++;
      if (rd !== e_rd) begin
        fails++; $display("FAIL unal_byte_rd %0d got %h want %h", i, rd, e_rd);
      end
    end
    mdl_apply(1'b0, 1'b1, 8'h21, 32'h0);
    do_txn(1'b0, 1'b1, 8'h21, 32'h0);
    tests++; if (rd !== e_rd) begin fails++; $display("FAIL unal_word_rd got %h want %h", rd, e_rd); end
    tests++; if (er !== e_er) begin fails++; $display("FAIL unal_rd_err got %b want %b", er, e_er); end
    tests++; if (pe !== 1'b0) begin fails++; $display("FAIL err_after_resp got %b want 0", pe); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 150; t++) begin
      logic        rw, size;
      logic [7:0]  a;
      logic [31:0] wd;
      rw   = 1'($urandom);
      size = 1'($urandom);
      a    = 8'($urandom);
      wd   = $urandom;
      mdl_apply(rw, size, a, wd);
      do_txn(rw, size, a, wd);
      tests++; if (lat != int'(W) + 1) begin fails++; $display("FAIL rnd_latency %0d got %0d want %0d", t, lat, W + 1); end
      tests++; if (rd !== e_rd) begin fails++; $display("FAIL rnd_rdata %0d rw %b sz %b a %h got %h want %h", t, rw, size, a, rd, e_rd); end
      tests++; if (er !== e_er) begin fails++; $display("FAIL rnd_err %0d got %b want %b", t, er, e_er); end
      tests++; if (sc != int'(W)) begin fails++; $display("FAIL rnd_stall_cycles %0d got %0d want %0d", t, sc, W); end
      tests++; if (br != 0) begin fails++; $display("FAIL rnd_ready_busy %0d got %0d want 0", t, br); end
      tests++; if ({pr, pv, pe} !== 3'b100) begin fails++; $display("FAIL rnd_post_resp %0d got %b want 100", t, {pr, pv, pe}); end
    end
  endtask

  task automatic test_back_to_back();
    time prev;
    prev = 0;
    for (int t = 0; t < 8; t++) begin
      logic [7:0] a;
      a = 8'($urandom);
      mdl_apply(1'b0, 1'b0, a, 32'h0);
      do_txn(1'b0, 1'b0, a, 32'h0);
      if (t > 0) begin
        tests++;
        if (ta - prev != (W + 2) * 10) begin
          fails++; $display("FAIL b2b_spacing %0d got %0t want %0d", t, ta - prev, (W + 2) * 10);
        end
      end
      tests++; if (rd !== e_rd) begin fails++; $display("FAIL b2b_rdata %0d got %h want %h", t, rd, e_rd); end
      prev = ta;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  a;
    logic [31:0] wd;
    a  = 8'($urandom) & 8'hFC;
    wd = ~exp_rd(1'b1, a);
    req_rw    = 1'b1;
    req_size  = 1'b1;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stall got %b want 1", stall); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl_last = 32'h0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", rsp_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_stall_after got %b want 0", stall); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL mid_rdata got %h want 0", rsp_rdata); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_next got %b want 1", req_ready); end
    mdl_apply(1'b0, 1'b1, a, 32'h0);
    do_txn(1'b0, 1'b1, a, 32'h0);
    tests++; if (rd !== e_rd) begin fails++; $display("FAIL mid_mem_kept got %h want %h", rd, e_rd); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_rw();
    test_align();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1);
  end

endmodule
